// File: rtl/int_rx_alu_if.sv
// Receive-side byte interface between the UART receiver (master) and the
// command front end (slave): write strobe, data byte and FIFO status flags.
interface int_rx_alu_if #(parameter int B = 8);
  logic         wr;
  logic [B-1:0] w_data;
  logic         full;
  logic         FIFO_empty;

  modport master (output wr, output w_data, input full, input FIFO_empty);
  modport slave  (input wr, input w_data, output full, output FIFO_empty);
endinterface

// File: rtl/int_rx_alu.sv
// UART calculator receive front end: 16-deep byte FIFO, "<A><op><B><CR>"
// parser and the ALU register bank that produces RESULTADO.
module int_rx_alu #(
  parameter int B = 8,
  parameter int W = 4
) (
  input  logic          CLK,
  input  logic          RESET,
  int_rx_alu_if.slave   rx,
  output logic          RD_FIFO,
  output logic [7:0]    CH,
  output logic [7:0]    DATOA,
  output logic [7:0]    DATOB,
  output logic [7:0]    OP,
  output logic [7:0]    data_out,
  output logic [2:0]    SEL,
  output logic [2:0]    STATE,
  output logic          FIN,
  output logic [7:0]    RESULTADO
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_PARSE   = 3'd2,
    S_LOAD_A  = 3'd3,
    S_LOAD_B  = 3'd4,
    S_LOAD_OP = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  // {valid, 6-bit opcode} for an operator character, all zero otherwise
  function automatic logic [6:0] op_decode(input logic [7:0] c);
    logic [6:0] r;
    case (c)
      8'h2B:   r = {1'b1, 6'h20};
      8'h2D:   r = {1'b1, 6'h22};
      8'h26:   r = {1'b1, 6'h24};
      8'h7C:   r = {1'b1, 6'h25};
      8'h5E:   r = {1'b1, 6'h26};
      8'h7E:   r = {1'b1, 6'h27};
      8'h3E:   r = {1'b1, 6'h02};
      8'h7D:   r = {1'b1, 6'h03};
      default: r = 7'h00;
    endcase
    return r;
  endfunction

  logic [B-1:0] mem_r [2**W];
  logic [W:0]   wr_ptr_r, rd_ptr_r;
  logic         empty_s, full_s, rd_en_s, wr_en_s;
  logic [B-1:0] r_data_s;

  // Extra pointer bit distinguishes full from empty when the indices match
  assign empty_s  = (wr_ptr_r == rd_ptr_r);
  assign full_s   = (wr_ptr_r[W-1:0] == rd_ptr_r[W-1:0]) && (wr_ptr_r[W] != rd_ptr_r[W]);
  assign rd_en_s  = RD_FIFO && !empty_s;
  assign wr_en_s  = rx.wr && (!full_s || rd_en_s);
  assign r_data_s = mem_r[rd_ptr_r[W-1:0]];

  assign rx.full       = full_s;
  assign rx.FIFO_empty = empty_s;

  // FIFO storage
  always_ff @(posedge CLK) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r[W-1:0]] <= rx.w_data;
    end
  end

  // FIFO pointers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + {{W{1'b0}}, 1'b1};
      if (rd_en_s) rd_ptr_r <= rd_ptr_r + {{W{1'b0}}, 1'b1};
    end
  end

  state_t      state_r, state_nx_s;
  logic        phase_r, rd_fifo_r, fin_r, is_digit_s;
  logic [7:0]  ch_r, datoa_r, datob_r, data_out_r, acc_s, acc_nx_s;
  logic [5:0]  op_r;
  logic [2:0]  sel_r;
  logic [6:0]  dec_s;

  // Character classification and next operand value
  always_comb begin
    is_digit_s = (ch_r >= 8'h30) && (ch_r <= 8'h39);
    dec_s      = op_decode(ch_r);
    acc_s      = phase_r ? datob_r : datoa_r;
    acc_nx_s   = acc_s * 8'd10 + {4'h0, ch_r[3:0]};
  end

  // Parser next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE:    state_nx_s = empty_s ? S_IDLE : S_FETCH;
      S_FETCH:   state_nx_s = S_PARSE;
      S_PARSE:   state_nx_s = (ch_r == 8'h0D && phase_r) ? S_LOAD_A : S_IDLE;
      S_LOAD_A:  state_nx_s = S_LOAD_B;
      S_LOAD_B:  state_nx_s = S_LOAD_OP;
      S_LOAD_OP: state_nx_s = S_DONE;
      S_DONE:    state_nx_s = S_IDLE;
      default:   state_nx_s = S_IDLE;
    endcase
  end

  // Parser state, operands and strobes registered against the next state
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r    <= S_IDLE;
      phase_r    <= 1'b0;
      rd_fifo_r  <= 1'b0;
      fin_r      <= 1'b0;
      ch_r       <= 8'h00;
      datoa_r    <= 8'h00;
      datob_r    <= 8'h00;
      op_r       <= 6'h00;
      sel_r      <= 3'b000;
      data_out_r <= 8'h00;
    end else begin
      state_r   <= state_nx_s;
      rd_fifo_r <= (state_nx_s == S_FETCH);
      fin_r     <= (state_nx_s == S_DONE);
      case (state_nx_s)
        S_LOAD_A:  begin sel_r <= 3'b001; data_out_r <= datoa_r;          end
        S_LOAD_B:  begin sel_r <= 3'b010; data_out_r <= datob_r;          end
        S_LOAD_OP: begin sel_r <= 3'b100; data_out_r <= {2'b00, op_r};    end
        default:   begin sel_r <= 3'b000; data_out_r <= 8'h00;            end
      endcase
      case (state_r)
        S_FETCH: ch_r <= r_data_s[7:0];
        S_PARSE: begin
          if (is_digit_s) begin
            if (phase_r) datob_r <= acc_nx_s;
            else         datoa_r <= acc_nx_s;
          end else if (dec_s[6]) begin
            op_r    <= dec_s[5:0];
            phase_r <= 1'b1;
          end
        end
        S_DONE: begin
          datoa_r <= 8'h00;
          datob_r <= 8'h00;
          phase_r <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  logic [7:0] alu_a_r, alu_b_r, result_s;
  logic [5:0] alu_op_r;

  // ALU register bank loaded by the one-hot SEL strobes
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      alu_a_r  <= 8'h00;
      alu_b_r  <= 8'h00;
      alu_op_r <= 6'h00;
    end else begin
      if (sel_r[0]) alu_a_r  <= data_out_r;
      if (sel_r[1]) alu_b_r  <= data_out_r;
      if (sel_r[2]) alu_op_r <= data_out_r[5:0];
    end
  end

  // Shift amount is the full byte: large shifts drain to zero or sign fill
  always_comb begin
    result_s = 8'h00;
    case (alu_op_r)
      6'h20:   result_s = alu_a_r + alu_b_r;
      6'h22:   result_s = alu_a_r - alu_b_r;
      6'h24:   result_s = alu_a_r & alu_b_r;
      6'h25:   result_s = alu_a_r | alu_b_r;
      6'h26:   result_s = alu_a_r ^ alu_b_r;
      6'h27:   result_s = ~(alu_a_r | alu_b_r);
      6'h02:   result_s = alu_a_r >> alu_b_r;
      6'h03:   result_s = $unsigned($signed(alu_a_r) >>> alu_b_r);
      default: result_s = 8'h00;
    endcase
  end

  assign RD_FIFO   = rd_fifo_r;
  assign CH        = ch_r;
  assign DATOA     = datoa_r;
  assign DATOB     = datob_r;
  assign OP        = {2'b00, op_r};
  assign data_out  = data_out_r;
  assign SEL       = sel_r;
  assign STATE     = state_r;
  assign FIN       = fin_r;
  assign RESULTADO = result_s;

endmodule

// File: tb/tb_int_rx_alu.sv
// Bench for int_rx_alu: table of calculator commands plus random expressions,
// all checked against a transaction-level model of the FIFO, parser and ALU.
module tb_int_rx_alu;
  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  int_rx_alu_if #(.B(8)) rx();
  logic       RD_FIFO, FIN;
  logic [7:0] CH, DATOA, DATOB, OP, data_out, RESULTADO;
  logic [2:0] SEL, STATE;

  int_rx_alu #(.B(8), .W(4)) dut (
    .CLK(CLK), .RESET(RESET), .rx(rx), .RD_FIFO(RD_FIFO), .CH(CH),
    .DATOA(DATOA), .DATOB(DATOB), .OP(OP), .data_out(data_out), .SEL(SEL),
    .STATE(STATE), .FIN(FIN), .RESULTADO(RESULTADO)
  );

  typedef struct { int a; int b; int op; int res; int cyc; } pend_t;
  typedef struct { string s; int gap; int nfin; int res; int a; int b; int op; } vec_t;

  pend_t      pend[$];
  logic [7:0] mq[$];
  int         a_m, b_m, op_m, phase_m;
  logic [7:0] exp_ch;
  int n_checks, n_fail, cyc, rd_count, fin_count;
  int last_res, last_a, last_b, last_op;
  int saw_full, saw_sel_b;
  vec_t tbl[13];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int model_op(input logic [7:0] c);
    case (c)
      "+": return 'h20;  "-": return 'h22;  "&": return 'h24;  "|": return 'h25;
      "^": return 'h26;  "~": return 'h27;  ">": return 'h02;  "}": return 'h03;
      default: return -1;
    endcase
  endfunction

  function automatic int model_res(input int a, input int b, input int op);
    int sa, p;
    sa = (a >= 128) ? a - 256 : a;
    p  = (b < 8) ? (1 << b) : 1;
    case (op)
      'h20: return (a + b) % 256;
      'h22: return (a - b + 256) % 256;
      'h24: return a & b;
      'h25: return a | b;
      'h26: return a ^ b;
      'h27: return 255 - (a | b);
      'h02: return (b >= 8) ? 0 : a / p;
      'h03: begin
        if (b >= 8) return (a >= 128) ? 255 : 0;
        if (sa < 0) return (-((-sa + p - 1) / p)) & 255;
        return sa / p;
      end
      default: return 0;
    endcase
  endfunction

  task automatic model_consume(input logic [7:0] c);
    pend_t p;
    if (c >= 8'h30 && c <= 8'h39) begin
      if (phase_m != 0) b_m = (b_m * 10 + (c - 8'h30)) % 256;
      else              a_m = (a_m * 10 + (c - 8'h30)) % 256;
    end else if (model_op(c) >= 0) begin
      op_m = model_op(c);
      phase_m = 1;
    end else if (c == 8'h0D && phase_m != 0) begin
      p = '{a_m, b_m, op_m, model_res(a_m, b_m, op_m), cyc};
      pend.push_back(p);
      a_m = 0; b_m = 0; phase_m = 0;
    end
  endtask

  task automatic model_reset();
    mq.delete(); pend.delete();
    a_m = 0; b_m = 0; op_m = 0; phase_m = 0; exp_ch = 8'h00;
  endtask

  // One clock: sample outputs mid-cycle, check them, advance model, drive inputs
  task automatic step(input logic do_wr, input logic [7:0] d);
    pend_t p;
    logic [7:0] c;
    int rd_fire, accept;
    @(negedge CLK);
    cyc++;
    chk("fifo_empty", rx.FIFO_empty, (mq.size() == 0) ? 1 : 0);
    chk("full", rx.full, (mq.size() == 16) ? 1 : 0);
    chk("ch", CH, exp_ch);
    if (rx.full) saw_full = 1;
    if (SEL == 3'b010) saw_sel_b = 1;
    if (SEL == 3'b000) chk("data_out_idle", data_out, 0);
    else if (pend.size() == 0) chk("sel_unexpected", SEL, 0);
    else begin
      p = pend[0];
      case (SEL)
        3'b001: begin chk("load_a_data", data_out, p.a);  chk("load_a_time", cyc - p.cyc, 2); end
        3'b010: begin chk("load_b_data", data_out, p.b);  chk("load_b_time", cyc - p.cyc, 3); end
        3'b100: begin chk("load_op_data", data_out, p.op); chk("load_op_time", cyc - p.cyc, 4); end
        default: chk("sel_onehot", SEL, 1);
      endcase
    end
    if (FIN) begin
      if (pend.size() == 0) chk("fin_unexpected", FIN, 0);
      else begin
        p = pend.pop_front();
        chk("fin_resultado", RESULTADO, p.res);
        chk("fin_datoa", DATOA, p.a);
        chk("fin_datob", DATOB, p.b);
        chk("fin_op", OP, p.op);
        chk("fin_time", cyc - p.cyc, 5);
        fin_count++;
        last_res = RESULTADO; last_a = DATOA; last_b = DATOB; last_op = OP;
      end
    end
    rd_fire = (RD_FIFO && mq.size() > 0) ? 1 : 0;
    if (RD_FIFO) begin
      rd_count++;
      chk("rd_nonempty", rd_fire, 1);
    end
    accept = (do_wr && (mq.size() < 16 || rd_fire != 0)) ? 1 : 0;
    if (rd_fire != 0) begin
      c = mq.pop_front();
      exp_ch = c;
      model_consume(c);
    end
    if (accept != 0) mq.push_back(d);
    rx.wr = do_wr;
    rx.w_data = d;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    step(1'b1, b);
    for (int k = 1; k < gap; k++) step(1'b0, 8'h00);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((mq.size() > 0 || pend.size() > 0) && g < 400) begin
      step(1'b0, 8'h00);
      g++;
    end
    chk("drain_bound", (g < 400) ? 1 : 0, 1);
    repeat (4) step(1'b0, 8'h00);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " RD_FIFO"}, RD_FIFO, 0);   chk({tag, " CH"}, CH, 0);
    chk({tag, " DATOA"}, DATOA, 0);       chk({tag, " DATOB"}, DATOB, 0);
    chk({tag, " OP"}, OP, 0);             chk({tag, " data_out"}, data_out, 0);
    chk({tag, " SEL"}, SEL, 0);           chk({tag, " STATE"}, STATE, 0);
    chk({tag, " FIN"}, FIN, 0);           chk({tag, " RESULTADO"}, RESULTADO, 0);
    chk({tag, " full"}, rx.full, 0);      chk({tag, " FIFO_empty"}, rx.FIFO_empty, 1);
  endtask

  task automatic run_vec(input vec_t v);
    int rc0, fc0;
    rc0 = rd_count;
    fc0 = fin_count;
    for (int j = 0; j < v.s.len(); j++) send_byte(v.s[j], v.gap);
    send_byte(8'h0D, v.gap);
    drain();
    chk({"rd_pulses ", v.s}, rd_count - rc0, v.s.len() + 1);
    chk({"fin_count ", v.s}, fin_count - fc0, v.nfin);
    if (v.nfin > 0) begin
      chk({"resultado ", v.s}, last_res, v.res);
      chk({"datoa ", v.s}, last_a, v.a);
      chk({"datob ", v.s}, last_b, v.b);
      chk({"op ", v.s}, last_op, v.op);
    end
    chk({"empty_after ", v.s}, rx.FIFO_empty, 1);
  endtask

  function automatic vec_t mk(input string s, input int gap, input int nfin,
                              input int res, input int a, input int b, input int op);
    vec_t v;
    v.s = s; v.gap = gap; v.nfin = nfin; v.res = res; v.a = a; v.b = b; v.op = op;
    return v;
  endfunction

  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    string ops;
    string s;
    int a, b, k, gap;
    n_checks = 0; n_fail = 0; cyc = 0; rd_count = 0; fin_count = 0;
    saw_full = 0; saw_sel_b = 0;
    model_reset();

    tbl[0]  = mk("170&15", 7, 1, 'h0A, 'hAA, 'h0F, 'h24);
    tbl[1]  = mk("200-56", 1, 1, 'h90, 'hC8, 'h38, 'h22);
    tbl[2]  = mk("300+1",  3, 1, 'h2D, 'h2C, 'h01, 'h20);
    tbl[3]  = mk("12",     2, 0, 0, 0, 0, 0);
    tbl[4]  = mk("+3",     2, 1, 'h0F, 'h0C, 'h03, 'h20);
    tbl[5]  = mk("5|10",   1, 1, 'h0F, 'h05, 'h0A, 'h25);
    tbl[6]  = mk("255~0",  2, 1, 'h00, 'hFF, 'h00, 'h27);
    tbl[7]  = mk("9^12",   1, 1, 'h05, 'h09, 'h0C, 'h26);
    tbl[8]  = mk("200>9",  1, 1, 'h00, 'hC8, 'h09, 'h02);
    tbl[9]  = mk("200}9",  1, 1, 'hFF, 'hC8, 'h09, 'h03);
    tbl[10] = mk("3-5",    1, 1, 'hFE, 'h03, 'h05, 'h22);
    tbl[11] = mk("7+*2",   2, 1, 'h09, 'h07, 'h02, 'h20);
    tbl[12] = mk("128}3",  1, 1, 'hF0, 'h80, 'h03, 'h03);

    RESET = 1'b1;
    rx.wr = 1'b0;
    rx.w_data = 8'h00;
    repeat (2) @(negedge CLK);
    chk_reset_outputs("reset");
    RESET = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(tbl[i]);

    // Mid-sequence reset: abort during LOAD_B, then a fresh command works
    saw_sel_b = 0;
    for (int j = 0; j < 4; j++) send_byte(8'(("25+7" >> (8 * (3 - j))) & 32'hFF), 1);
    send_byte(8'h0D, 1);
    for (int g = 0; g < 60 && saw_sel_b == 0; g++) step(1'b0, 8'h00);
    chk("reach_load_b", saw_sel_b, 1);
    chk("state_load_b", STATE, 4);
    #2;
    RESET = 1'b1;
    #1;
    chk_reset_outputs("midreset");
    model_reset();
    @(negedge CLK);
    chk_reset_outputs("midreset_hold");
    RESET = 1'b0;
    run_vec(tbl[12]);

    // Back-to-back burst: parser drains slower than writes arrive, so FIFO fills
    saw_full = 0;
    for (int i = 0; i < 30; i++) step(1'b1, 8'(8'h30 + (i % 10)));
    drain();
    chk("saw_full", saw_full, 1);
    send_byte("+", 1);
    send_byte("1", 1);
    send_byte(8'h0D, 1);
    drain();

    ops = "+-&|^~>}";
    for (int r = 0; r < 40; r++) begin
      a = $urandom_range(0, 999);
      b = (r % 3 == 0) ? $urandom_range(0, 400) : $urandom_range(0, 12);
      k = $urandom_range(0, 8);
      s = $sformatf("%0d", a);
      if ($urandom_range(0, 5) == 0) s = {s, "x"};
      if (k < 8) s = {s, ops.substr(k, k)};
      s = {s, $sformatf("%0d", b)};
      gap = $urandom_range(1, 4);
      for (int j = 0; j < s.len(); j++) send_byte(s[j], gap);
      send_byte(8'h0D, gap);
      if (r % 10 == 9) drain();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
